// File: rtl/game_state_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | game_pkg : shared types and BCD helper for the game sequencer slice.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HIT  = 2'd2,
      OVER = 2'd3
   } state_t;

   typedef logic [7:0] bcd2_t;

   localparam bcd2_t BCD_MAX = 8'h99;

   // Two-digit packed BCD increment that sticks at 99.
   function automatic bcd2_t bcd_inc(input bcd2_t v);
      bcd2_t r;
      if (v == BCD_MAX)
         r = v;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_state_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | game_if : event inputs and status outputs of the game sequencer.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface game_if;
   import game_pkg::*;

   logic   frame_clk;
   logic   collision;
   logic   ground_hit;
   logic   pipe_passed;
   logic   start_key;
   logic   frame_tick;
   logic   game_active;
   logic   blink;
   logic   game_over;
   logic   coll_clr;
   state_t state;
   logic [1:0] lives;
   bcd2_t  score;
   bcd2_t  high_score;

   modport master (
      output frame_clk, collision, ground_hit, pipe_passed, start_key,
      input  frame_tick, game_active, blink, game_over, coll_clr,
             state, lives, score, high_score
   );

   modport slave (
      input  frame_clk, collision, ground_hit, pipe_passed, start_key,
      output frame_tick, game_active, blink, game_over, coll_clr,
             state, lives, score, high_score
   );

endinterface

`default_nettype wire

// File: rtl/game_state_ctrl_bcd.sv
// +--------------------------------------------------------------------------+
// | bcd_score_counter : saturating 2-digit BCD score with greater-than test. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_score_counter
   import game_pkg::*;
(
   input  wire   Clk,
   input  wire   Reset,
   input  logic  clr_i,
   input  logic  inc_i,
   input  bcd2_t cmp_i,
   output bcd2_t score_o,
   output bcd2_t next_o,
   output logic  gt_o
);

   bcd2_t score_q;
   bcd2_t score_d;

   always_comb begin
      score_d = score_q;
      if (clr_i)
         score_d = '0;
      else if (inc_i)
         score_d = bcd_inc(score_q);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         score_q <= '0;
      else
         score_q <= score_d;
   end

   // Valid packed BCD orders exactly like unsigned binary.
   assign gt_o    = (score_d > cmp_i);
   assign score_o = score_q;
   assign next_o  = score_d;

endmodule

`default_nettype wire

// File: rtl/game_state_ctrl.sv
// +--------------------------------------------------------------------------+
// | game_state_ctrl : frame-based crash/life/score sequencer for the game.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module game_state_ctrl
   import game_pkg::*;
#(
   parameter int LIVES            = 3,
   parameter int HIT_FRAMES       = 2,
   parameter int INVULN_FRAMES    = 90,
   parameter int OVER_HOLD_FRAMES = 60
)(
   input wire    Clk,
   input wire    Reset,
   game_if.slave bus
);

   localparam logic [1:0] c_lives  = 2'(LIVES);
   localparam logic [2:0] c_hits   = 3'(HIT_FRAMES);
   localparam logic [7:0] c_invuln = 8'(INVULN_FRAMES);
   localparam logic [7:0] c_hold   = 8'(OVER_HOLD_FRAMES);

   state_t     state_q;
   logic [1:0] lives_q;
   logic [2:0] hit_cnt_q;
   logic [7:0] invuln_q, hold_q;
   logic       frame_clk_q, start_key_q, hit_latch_q, gnd_latch_q;
   logic       game_active_q, blink_q, game_over_q, coll_clr_q;
   bcd2_t      high_score_q;

   logic       w_frame_tick, w_start_rise, w_frame_hit, w_frame_gnd;
   logic       w_crash, w_score_inc, w_start_play, w_score_gt;
   logic [2:0] w_hit_inc;
   logic [7:0] w_invuln_dec;
   bcd2_t      w_score, w_score_next;

   assign w_frame_tick = bus.frame_clk & ~frame_clk_q;
   assign w_start_rise = bus.start_key & ~start_key_q;
   // Hits arriving in the tick cycle still belong to the frame being closed.
   assign w_frame_hit  = hit_latch_q | bus.collision | bus.ground_hit;
   assign w_frame_gnd  = gnd_latch_q | bus.ground_hit;
   assign w_hit_inc    = hit_cnt_q + 3'd1;
   assign w_crash      = w_frame_tick &
                         (w_frame_gnd | (w_frame_hit & (w_hit_inc >= c_hits)));
   assign w_score_inc  = bus.pipe_passed & ((state_q == PLAY) | (state_q == HIT));
   assign w_start_play = (state_q == IDLE) & w_start_rise;
   assign w_invuln_dec = invuln_q - 8'd1;

   bcd_score_counter u_score (
      .Clk    (Clk),
      .Reset  (Reset),
      .clr_i  (w_start_play),
      .inc_i  (w_score_inc),
      .cmp_i  (high_score_q),
      .score_o(w_score),
      .next_o (w_score_next),
      .gt_o   (w_score_gt)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= IDLE;
         lives_q       <= c_lives;
         hit_cnt_q     <= '0;
         invuln_q      <= '0;
         hold_q        <= '0;
         frame_clk_q   <= 1'b0;
         start_key_q   <= 1'b0;
         hit_latch_q   <= 1'b0;
         gnd_latch_q   <= 1'b0;
         game_active_q <= 1'b0;
         blink_q       <= 1'b0;
         game_over_q   <= 1'b0;
         coll_clr_q    <= 1'b0;
         high_score_q  <= '0;
      end else begin
         frame_clk_q <= bus.frame_clk;
         start_key_q <= bus.start_key;
         hit_latch_q <= w_frame_tick ? 1'b0 : w_frame_hit;
         gnd_latch_q <= w_frame_tick ? 1'b0 : w_frame_gnd;
         coll_clr_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (w_start_rise) begin
                  state_q       <= PLAY;
                  lives_q       <= c_lives;
                  hit_cnt_q     <= '0;
                  coll_clr_q    <= 1'b1;
                  game_active_q <= 1'b1;
               end
            end
            PLAY: begin
               if (w_crash) begin
                  hit_cnt_q <= '0;
                  if (lives_q > 2'd1) begin
                     state_q  <= HIT;
                     lives_q  <= lives_q - 2'd1;
                     invuln_q <= c_invuln;
                     blink_q  <= c_invuln[2];
                  end else begin
                     state_q       <= OVER;
                     lives_q       <= 2'd0;
                     hold_q        <= c_hold;
                     game_active_q <= 1'b0;
                     game_over_q   <= 1'b1;
                     if (w_score_gt)
                        high_score_q <= w_score_next;
                  end
               end else if (w_frame_tick) begin
                  hit_cnt_q <= w_frame_hit ? w_hit_inc : 3'd0;
               end
            end
            HIT: begin
               if (w_frame_tick) begin
                  invuln_q <= w_invuln_dec;
                  if (invuln_q == 8'd1) begin
                     state_q    <= PLAY;
                     blink_q    <= 1'b0;
                     coll_clr_q <= 1'b1;
                  end else begin
                     blink_q <= w_invuln_dec[2];
                  end
               end
            end
            OVER: begin
               if (w_start_rise && (hold_q == 8'd0)) begin
                  state_q     <= IDLE;
                  game_over_q <= 1'b0;
               end else if (w_frame_tick && (hold_q != 8'd0)) begin
                  hold_q <= hold_q - 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.frame_tick  = w_frame_tick;
   assign bus.game_active = game_active_q;
   assign bus.blink       = blink_q;
   assign bus.game_over   = game_over_q;
   assign bus.coll_clr    = coll_clr_q;
   assign bus.state       = state_q;
   assign bus.lives       = lives_q;
   assign bus.score       = w_score;
   assign bus.high_score  = high_score_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_game_state_ctrl : scoreboard bench with a decimal reference model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_game_state_ctrl;
   import game_pkg::*;

   localparam int LIVES            = 3;
   localparam int HIT_FRAMES       = 2;
   localparam int INVULN_FRAMES    = 90;
   localparam int OVER_HOLD_FRAMES = 60;
   localparam int FRAME_CYC        = 4;

   logic Clk = 1'b0;
   logic Reset;
   game_if bus();

   game_state_ctrl #(
      .LIVES           (LIVES),
      .HIT_FRAMES      (HIT_FRAMES),
      .INVULN_FRAMES   (INVULN_FRAMES),
      .OVER_HOLD_FRAMES(OVER_HOLD_FRAMES)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [1:0] st;
      logic [1:0] lives;
      logic [7:0] score;
      logic [7:0] hi;
      logic       tick;
      logic       act;
      logic       blink;
      logic       over;
      logic       clr;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cnt    = 0;

   // Reference model: plain counters and decimal score values.
   state_t m_st;
   int     m_lives, m_score, m_hi, m_hits, m_inv, m_hold;
   bit     m_lat, m_glat, m_fclk_p, m_sk_p, m_clr;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_st = IDLE; m_lives = LIVES; m_score = 0; m_hi = 0; m_hits = 0;
      m_inv = 0; m_hold = 0; m_lat = 0; m_glat = 0; m_fclk_p = 0;
      m_sk_p = 0; m_clr = 0;
   endtask

   task automatic model_step(input bit fclk, coll, gnd, pp, sk);
      bit tick, rise, fhit, fgnd;
      int run;
      tick  = fclk && !m_fclk_p;
      rise  = sk && !m_sk_p;
      fhit  = m_lat || coll || gnd;
      fgnd  = m_glat || gnd;
      m_clr = 0;
      if ((m_st == PLAY || m_st == HIT) && pp && m_score < 99)
         m_score = m_score + 1;
      case (m_st)
         IDLE: if (rise) begin
            m_st = PLAY; m_score = 0; m_lives = LIVES; m_hits = 0; m_clr = 1;
         end
         PLAY: if (tick) begin
            run = fhit ? m_hits + 1 : 0;
            if (fgnd || run >= HIT_FRAMES) begin
               m_hits = 0;
               if (m_lives > 1) begin
                  m_lives--; m_st = HIT; m_inv = INVULN_FRAMES;
               end else begin
                  m_lives = 0; m_st = OVER; m_hold = OVER_HOLD_FRAMES;
                  if (m_score > m_hi) m_hi = m_score;
               end
            end else begin
               m_hits = run;
            end
         end
         HIT: if (tick) begin
            m_inv--;
            if (m_inv == 0) begin
               m_st = PLAY; m_clr = 1;
            end
         end
         OVER: begin
            if (rise && m_hold == 0) m_st = IDLE;
            else if (tick && m_hold > 0) m_hold--;
         end
         default: ;
      endcase
      m_lat    = tick ? 1'b0 : fhit;
      m_glat   = tick ? 1'b0 : fgnd;
      m_fclk_p = fclk;
      m_sk_p   = sk;
   endtask

   task automatic cyc(input bit coll, gnd, pp, sk);
      bit   fclk;
      exp_t e;
      fclk = (cnt % FRAME_CYC) < (FRAME_CYC / 2);
      cnt++;
      @(negedge Clk);
      bus.frame_clk   = fclk;
      bus.collision   = coll;
      bus.ground_hit  = gnd;
      bus.pipe_passed = pp;
      bus.start_key   = sk;
      e.st    = m_st;
      e.lives = 2'(m_lives);
      e.score = to_bcd(m_score);
      e.hi    = to_bcd(m_hi);
      e.tick  = fclk && !m_fclk_p;
      e.act   = (m_st == PLAY) || (m_st == HIT);
      e.blink = (m_st == HIT) && (((m_inv / 4) % 2) == 1);
      e.over  = (m_st == OVER);
      e.clr   = m_clr;
      q.push_back(e);
      model_step(fclk, coll, gnd, pp, sk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, int'(bus.state), int'(IDLE));
      chk({tag, "_lives"}, int'(bus.lives), LIVES);
      chk({tag, "_score"}, int'(bus.score), 0);
      chk({tag, "_high"},  int'(bus.high_score), 0);
      chk({tag, "_flags"}, int'({bus.game_active, bus.blink, bus.game_over, bus.coll_clr}), 0);
   endtask

   // Monitor: every cycle the DUT presents a full status word.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",       int'(bus.state),       int'(e.st));
            chk("lives",       int'(bus.lives),       int'(e.lives));
            chk("score",       int'(bus.score),       int'(e.score));
            chk("high_score",  int'(bus.high_score),  int'(e.hi));
            chk("frame_tick",  int'(bus.frame_tick),  int'(e.tick));
            chk("game_active", int'(bus.game_active), int'(e.act));
            chk("blink",       int'(bus.blink),       int'(e.blink));
            chk("game_over",   int'(bus.game_over),   int'(e.over));
            chk("coll_clr",    int'(bus.coll_clr),    int'(e.clr));
         end
      end
   end

   initial begin
      int k;
      bit sk;
      Reset           = 1'b0;
      bus.frame_clk   = 1'b0;
      bus.collision   = 1'b0;
      bus.ground_hit  = 1'b0;
      bus.pipe_passed = 1'b0;
      bus.start_key   = 1'b0;
      #1 Reset = 1'b1;
      #2 check_reset_outputs("por");
      #9 Reset = 1'b0;
      model_reset();

      // Start a round and clear three pipes.
      repeat (3) cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 1);
      repeat (3) begin
         cyc(0, 0, 1, 1);
         cyc(0, 0, 0, 1);
      end
      // Drive the score through 09->10 and up to saturation.
      repeat (110) begin
         cyc(0, 0, 1, 1);
         cyc(0, 0, 0, 1);
      end
      repeat (2 * FRAME_CYC) cyc(0, 1, 0, 1);

      // Randomised play: collisions, ground, pipes and start presses.
      sk = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) sk = ~sk;
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0,
             $urandom_range(0, 5) == 0, sk);
      end

      // Steer into HIT, then hit the block with an unaligned reset.
      k = 0;
      while (m_st != HIT && k < 3000) begin
         cyc(1, 0, $urandom_range(0, 3) == 0, k[1]);
         k++;
      end
      repeat (10) cyc(0, 0, 0, 0);
      chk("reach_hit", int'(bus.state), int'(HIT));
      @(negedge Clk);
      #3 Reset = 1'b1;
      #1 check_reset_outputs("async");
      #3 Reset = 1'b0;
      model_reset();
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 19) == 0, 1'b0, $urandom_range(0, 3) == 0, i[3]);

      repeat (3) @(negedge Clk);
      #4;
      chk("drain", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer for the Flappy Bird datapath.
- Consumes the per-pixel registered collision flag, the ground-hit flag, pipe-pass pulses and the start key.
- Turns them into per-frame crash decisions, life and score accounting, and motion/display enables for the ball, pipe and VGA colour logic.
- Sits between the collision detector and the motion/colour mappers; it also drives collision-detector Reset so stale hits never leak across rounds.

Parameters:
- LIVES, 3, lives per round (1..3).
- HIT_FRAMES, 2, consecutive hit frames required to register a crash (1..7).
- INVULN_FRAMES, 90, invulnerable frames after losing a non-final life (1..255).
- OVER_HOLD_FRAMES, 60, frames in OVER before a start press is accepted (1..255).

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  VGA vsync-derived frame signal, synchronous to Clk.
- collision  in  1  registered ball/pipe overlap flag from the collision detector.
- ground_hit  in  1  ball bottom at or below floor; level.
- pipe_passed  in  1  single-cycle pulse when the ball clears a pipe pair.
- start_key  in  1  flap/start key, synchronous level.
- frame_tick  out  1  one-cycle pulse on frame_clk rising edge.
- game_active  out  1  motion enable for ball and pipes.
- blink  out  1  ball-hide strobe during invulnerability.
- game_over  out  1  high in OVER.
- coll_clr  out  1  one-cycle reset pulse to the collision detector.
- state  out  2  current state (game_pkg::state_t).
- lives  out  2  remaining lives.
- score  out  8  2-digit packed BCD score.
- high_score  out  8  2-digit packed BCD best score.

Behaviour:
- Reset values: state=IDLE, lives=LIVES, score=0x00, high_score=0x00, all 1-bit outputs 0, all internal counters and latches 0.
- Edge detect: frame_clk and start_key are registered once.
  - frame_tick = frame_clk & ~frame_clk_q.
  - start_rise = start_key & ~start_key_q.
- Hit latch:
  - Set on any Clk with collision=1 or ground_hit=1.
  - On frame_tick, the latch value (OR the same-cycle inputs) becomes frame_hit, and the latch clears.
  - A hit in the tick cycle counts toward the closing frame.
- Debounce: hit_cnt increments on frame_tick when frame_hit=1, clears when frame_hit=0. crash=1 when hit_cnt reaches HIT_FRAMES.
  - ground_hit seen in a frame forces an immediate crash at that tick, with no debounce.
- IDLE: game_active=0.
  - start_rise -> PLAY.
  - On that transition: score=0, lives=LIVES, hit_cnt=0, coll_clr pulses.
- PLAY: game_active=1.
  - Crash with lives>1 -> HIT, lives-1, invuln=INVULN_FRAMES, hit_cnt=0.
  - Crash with lives==1 -> OVER, lives=0, hold=OVER_HOLD_FRAMES.
- HIT: game_active=1.
  - blink = invuln[2] (toggles every 4 frames).
  - Collisions and ground ignored; latch still cleared each tick; hit_cnt held at 0.
  - invuln decrements on frame_tick. At the tick where it reaches 0 -> PLAY, blink=0, coll_clr pulses.
- OVER: game_active=0, game_over=1.
  - hold decrements per frame_tick, saturating at 0.
  - start_rise while hold≠0 is ignored.
  - start_rise with hold==0 -> IDLE. score retained until the next IDLE->PLAY.
- Score:
  - pipe_passed in PLAY or HIT increments BCD score: ones wrap 9->0 with carry; saturate at 0x99.
  - pipe_passed in IDLE/OVER is ignored.
  - pipe_passed and a crash in the same cycle: the score increment is still applied.
- High score: on the PLAY->OVER transition, if score > high_score (BCD compare) then high_score=score, visible in the first OVER cycle. Cleared only by Reset.
- Simultaneous events:
  - start_rise and frame_tick together: the state transition takes priority; the latch still clears.
  - Reset asserted mid-round returns all registers to reset values asynchronously.

Decomposition:
- game_pkg holds:
  - state_t enum {IDLE=2'd0, PLAY=2'd1, HIT=2'd2, OVER=2'd3};
  - typedef bcd2_t (logic [7:0]);
  - constant BCD_MAX=8'h99.
- One sub-module, bcd_score_counter:
  - Handles clear, increment, saturate and BCD greater-than compare.
  - Instantiated once for score; high_score register stays in the parent.

Test Plan:
1. Reset, start_key rise, 3 pipe_passed pulses -> state=PLAY, game_active=1, score=0x03, lives=3, coll_clr pulsed once.
2. collision held 1 cycle in each of 2 consecutive frames (HIT_FRAMES=2) -> at the second frame_tick: state=HIT, lives=2, blink toggles every 4 ticks. After 90 ticks: state=PLAY, coll_clr pulse.
3. collision in 1 frame only, then a clean frame -> no crash, hit_cnt=0, lives unchanged. Collision during HIT -> ignored.
4. ground_hit with lives=1, score=0x12, high_score=0x07 -> next tick: state=OVER, game_over=1, high_score=0x12. start_rise at frame 30 ignored; start_rise after 60 ticks -> IDLE.
5. Score at 0x09 plus pipe_passed -> 0x10. Score at 0x99 plus pipe_passed -> stays 0x99.
6. Reset asserted mid-HIT, not aligned to Clk -> outputs immediately at reset values, high_score=0x00.
